// File: rtl/pdc_ram_mp_if.sv
// Bus bundle for the multi-port predecode RAM: packed read/write port groups plus init status.
interface pdc_ram_mp_if #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 11,
    parameter int RD_PORTS = 3,
    parameter int WR_PORTS = 2
) ();
    logic [RD_PORTS*ADDR_W-1:0] read_addr;
    logic [RD_PORTS-1:0]        read_clkEn;
    logic [RD_PORTS*WIDTH-1:0]  read_data;
    logic [WR_PORTS*ADDR_W-1:0] write_addr;
    logic [WR_PORTS*WIDTH-1:0]  write_data;
    logic [WR_PORTS-1:0]        write_wen;
    logic                       init_busy;

    modport master (
        output read_addr, read_clkEn, write_addr, write_data, write_wen,
        input  read_data, init_busy
    );

    modport slave (
        input  read_addr, read_clkEn, write_addr, write_data, write_wen,
        output read_data, init_busy
    );
endinterface

// File: rtl/pdc_ram_mp.sv
// Multi-port predecode RAM with post-reset init sweep, highest-port write priority, optional write-first forwarding.
// Latency: address captured at edge N, data registered at edge N+1; init sweep takes DEPTH cycles after reset.
// Backpressure: none; reads always accepted, writes dropped only while init_busy is high.
module pdc_ram_mp #(
    parameter int                WIDTH    = 64,
    parameter int                ADDR_W   = 11,
    parameter int                RD_PORTS = 3,
    parameter int                WR_PORTS = 2,
    parameter int                BYPASS   = 1,
    parameter logic [WIDTH-1:0]  INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    pdc_ram_mp_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_SWEEP, ST_RUN} state_e;

    state_e                               state_q, state_d;
    logic [ADDR_W-1:0]                    cnt_q, cnt_d;
    logic [RD_PORTS-1:0][ADDR_W-1:0]      addr0_q, addr0_d;
    logic [RD_PORTS-1:0][WIDTH-1:0]       rd_q, rd_d;
    logic [RD_PORTS-1:0][ADDR_W-1:0]      rd_addr;
    logic [WR_PORTS-1:0][ADDR_W-1:0]      wr_addr;
    logic [WR_PORTS-1:0][WIDTH-1:0]       wr_dat;
    logic [WR_PORTS-1:0]                  wr_vld;
    logic                                 busy;
    logic [WIDTH-1:0]                     ram_q [DEPTH];

    assign rd_addr = bus.read_addr;
    assign wr_addr = bus.write_addr;
    assign wr_dat  = bus.write_data;
    assign busy    = (state_q == ST_SWEEP);
    assign wr_vld  = busy ? '0 : bus.write_wen;

    assign bus.init_busy = busy;
    assign bus.read_data = rd_q;

    // Sweep walks every entry once; the cycle that writes the last entry is the final busy cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = ST_SWEEP;
            end
        endcase
    end

    // Later write ports overwrite earlier matches, so forwarding agrees with the array's priority.
    always_comb begin
        addr0_d = addr0_q;
        rd_d    = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            if (bus.read_clkEn[k]) begin
                addr0_d[k] = rd_addr[k];
            end
            rd_d[k] = ram_q[addr0_q[k]];
            if (BYPASS != 0) begin
                for (int j = 0; j < WR_PORTS; j++) begin
                    if (wr_vld[j] && (wr_addr[j] == addr0_q[k])) begin
                        rd_d[k] = wr_dat[j];
                    end
                end
            end
            if (busy) begin
                rd_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
            addr0_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr0_q <= addr0_d;
            rd_q    <= rd_d;
        end
    end

    // Array storage is never reset; the sweep clears it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                ram_q[cnt_q] <= INIT_VAL;
            end else begin
                for (int j = 0; j < WR_PORTS; j++) begin
                    if (wr_vld[j]) begin
                        ram_q[wr_addr[j]] <= wr_dat[j];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pdc_ram_mp.sv
// Bench for pdc_ram_mp: write-first and read-first instances driven identically, checked against an array model.
module tb_pdc_ram_mp;
    localparam int W     = 64;
    localparam int AW    = 11;
    localparam int NR    = 3;
    localparam int NW    = 2;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pdc_ram_mp_if #(.WIDTH(W), .ADDR_W(AW), .RD_PORTS(NR), .WR_PORTS(NW)) bus ();
    pdc_ram_mp_if #(.WIDTH(W), .ADDR_W(AW), .RD_PORTS(NR), .WR_PORTS(NW)) bus_rf ();

    assign bus_rf.read_addr  = bus.read_addr;
    assign bus_rf.read_clkEn = bus.read_clkEn;
    assign bus_rf.write_addr = bus.write_addr;
    assign bus_rf.write_data = bus.write_data;
    assign bus_rf.write_wen  = bus.write_wen;

    pdc_ram_mp #(.WIDTH(W), .ADDR_W(AW), .RD_PORTS(NR), .WR_PORTS(NW), .BYPASS(1), .INIT_VAL('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pdc_ram_mp #(.WIDTH(W), .ADDR_W(AW), .RD_PORTS(NR), .WR_PORTS(NW), .BYPASS(0), .INIT_VAL('0)) dut_rf (
        .clk (clk),
        .rst (rst),
        .bus (bus_rf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: whole-array contents plus per-port held address and expected outputs.
    logic [W-1:0] m_mem [DEPTH];
    int           m_addr0 [NR];
    logic [W-1:0] m_rd1 [NR];
    logic [W-1:0] m_rd0 [NR];
    logic         m_busy = 1'b1;
    int           m_cnt  = 0;

    typedef struct {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [W-1:0]  wdata;
        logic [AW-1:0] raddr;
        logic [W-1:0]  exp;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rdp(input int k);
        return bus.read_data[k*W +: W];
    endfunction

    function automatic logic [W-1:0] rdp_rf(input int k);
        return bus_rf.read_data[k*W +: W];
    endfunction

    task automatic idle();
        bus.read_clkEn = '0;
        bus.write_wen  = '0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a, input logic en);
        bus.read_addr[k*AW +: AW] = a;
        bus.read_clkEn[k]         = en;
    endtask

    task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.write_addr[j*AW +: AW] = a;
        bus.write_data[j*W +: W]   = d;
        bus.write_wen[j]           = 1'b1;
    endtask

    task automatic model_edge();
        logic [W-1:0] win [int];
        logic [W-1:0] old;
        if (rst) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            for (int k = 0; k < NR; k++) begin
                m_addr0[k] = 0;
                m_rd1[k]   = '0;
                m_rd0[k]   = '0;
            end
        end else begin
            if (m_busy) begin
                m_mem[m_cnt] = '0;
                m_cnt++;
                if (m_cnt == DEPTH) m_busy = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    m_rd1[k] = '0;
                    m_rd0[k] = '0;
                end
            end else begin
                for (int j = 0; j < NW; j++) begin
                    if (bus.write_wen[j]) win[int'(bus.write_addr[j*AW +: AW])] = bus.write_data[j*W +: W];
                end
                for (int k = 0; k < NR; k++) begin
                    old      = m_mem[m_addr0[k]];
                    m_rd0[k] = old;
                    m_rd1[k] = win.exists(m_addr0[k]) ? win[m_addr0[k]] : old;
                end
                foreach (win[a]) m_mem[a] = win[a];
            end
            for (int k = 0; k < NR; k++) begin
                if (bus.read_clkEn[k]) m_addr0[k] = int'(bus.read_addr[k*AW +: AW]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy_bp", {63'd0, bus.init_busy}, {63'd0, m_busy});
        chk("busy_rf", {63'd0, bus_rf.init_busy}, {63'd0, m_busy});
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("model_rd_bp%0d", k), rdp(k), m_rd1[k]);
            chk($sformatf("model_rd_rf%0d", k), rdp_rf(k), m_rd0[k]);
        end
    endtask

    task automatic sweep_len(output int n);
        n = 0;
        while (bus.init_busy === 1'b1 && n < 5000) begin
            n++;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [AW-1:0] ra [3];

        vecs[0] = '{1'b1, 11'h100, 64'h11,                  11'h100, 64'h11};
        vecs[1] = '{1'b1, 11'h101, 64'h22,                  11'h100, 64'h11};
        vecs[2] = '{1'b0, 11'h000, 64'h0,                   11'h101, 64'h22};
        vecs[3] = '{1'b0, 11'h000, 64'h0,                   11'h3FF, 64'h0};
        vecs[4] = '{1'b1, 11'h7FF, 64'hFFFF_FFFF_FFFF_FFFF, 11'h7FF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{1'b1, 11'h100, 64'h33,                  11'h100, 64'h33};

        bus.read_addr  = '0;
        bus.write_addr = '0;
        bus.write_data = '0;
        idle();

        // Reset and full sweep
        rst = 1'b1;
        step();
        step();
        chk("reset_busy", {63'd0, bus.init_busy}, 64'd1);
        for (int k = 0; k < NR; k++) chk($sformatf("reset_rd%0d", k), rdp(k), 64'd0);
        rst = 1'b0;
        sweep_len(n);
        chk("sweep_len", 64'(n), 64'd2048);
        chk("busy_after_sweep", {63'd0, bus.init_busy}, 64'd0);

        ra[0] = 11'd0; ra[1] = 11'd1023; ra[2] = 11'd2047;
        for (int i = 0; i < 3; i++) begin
            idle();
            for (int k = 0; k < NR; k++) set_rd(k, ra[i], 1'b1);
            step();
            idle();
            step();
            for (int k = 0; k < NR; k++) chk($sformatf("init_zero_a%0d_p%0d", ra[i], k), rdp(k), 64'd0);
        end

        // Table-driven write/read vectors
        for (int v = 0; v < 6; v++) begin
            idle();
            if (vecs[v].wen) set_wr(0, vecs[v].waddr, vecs[v].wdata);
            step();
            idle();
            for (int k = 0; k < NR; k++) set_rd(k, vecs[v].raddr, 1'b1);
            step();
            idle();
            step();
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("vec%0d_bp_p%0d", v, k), rdp(k), vecs[v].exp);
                chk($sformatf("vec%0d_rf_p%0d", v, k), rdp_rf(k), vecs[v].exp);
            end
        end

        // Latency: port1 last held 0x100 (0x33), so edge N still shows old data
        idle();
        set_wr(0, 11'h155, 64'hDEAD_BEEF);
        step();
        idle();
        set_rd(1, 11'h155, 1'b1);
        step();
        idle();
        chk("lat_edgeN", rdp(1), 64'h33);
        step();
        chk("lat_edgeN1", rdp(1), 64'hDEAD_BEEF);

        // Held address on port2 while other addresses are presented
        idle();
        set_rd(2, 11'h010, 1'b1);
        step();
        for (int c = 0; c < 5; c++) begin
            idle();
            set_rd(2, 11'h100, 1'b0);
            if (c == 2) set_wr(0, 11'h010, 64'h1234);
            step();
            if (c < 2) begin
                chk($sformatf("hold_pre_c%0d", c), rdp(2), 64'h0);
            end else if (c == 2) begin
                chk("hold_write_bp", rdp(2), 64'h1234);
                chk("hold_write_rf", rdp_rf(2), 64'h0);
            end else begin
                chk($sformatf("hold_post_c%0d", c), rdp(2), 64'h1234);
            end
        end

        // Write collision: higher port wins
        idle();
        set_wr(0, 11'h020, 64'hAAAA);
        set_wr(1, 11'h020, 64'h5555);
        step();
        idle();
        set_rd(0, 11'h020, 1'b1);
        step();
        idle();
        step();
        chk("collision_bp", rdp(0), 64'h5555);
        chk("collision_rf", rdp_rf(0), 64'h5555);

        // Bypass versus read-first
        idle();
        set_wr(0, 11'h030, 64'h1);
        set_rd(0, 11'h030, 1'b1);
        step();
        idle();
        step();
        chk("byp_pre_bp", rdp(0), 64'h1);
        chk("byp_pre_rf", rdp_rf(0), 64'h1);
        set_wr(0, 11'h030, 64'h2);
        step();
        chk("byp_edge_bp", rdp(0), 64'h2);
        chk("byp_edge_rf", rdp_rf(0), 64'h1);
        idle();
        step();
        chk("byp_next_bp", rdp(0), 64'h2);
        chk("byp_next_rf", rdp_rf(0), 64'h2);

        // Random traffic over a small address pool to provoke collisions and forwarding
        for (int i = 0; i < 3000; i++) begin
            idle();
            for (int k = 0; k < NR; k++) begin
                set_rd(k, AW'($urandom_range(0, 15)) | ($urandom_range(0, 1) != 0 ? 11'h7F0 : 11'h000),
                       1'($urandom_range(0, 1)));
            end
            for (int j = 0; j < NW; j++) begin
                if ($urandom_range(0, 1) != 0)
                    set_wr(j, AW'($urandom_range(0, 15)) | ($urandom_range(0, 1) != 0 ? 11'h7F0 : 11'h000),
                           {$urandom, $urandom});
            end
            step();
        end

        // Reset mid-sweep with write attempts to 0x7FF throughout
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        set_wr(0, 11'h7FF, 64'hFFFF);
        set_wr(1, 11'h7FF, 64'hFFFF);
        for (int c = 0; c < 700; c++) step();
        chk("midsweep_busy", {63'd0, bus.init_busy}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sweep_len(n);
        chk("resweep_len", 64'(n), 64'd2048);
        idle();
        set_rd(0, 11'h7FF, 1'b1);
        set_rd(1, 11'h7FF, 1'b1);
        step();
        idle();
        step();
        chk("midsweep_7ff_bp", rdp(0), 64'd0);
        chk("midsweep_7ff_rf", rdp_rf(1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
